// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the shift-register load/shift sequencer.
package shift_ctrl_pkg;

  // Default shift register width used when the parent does not override it.
  localparam int DEFAULT_WIDTH = 4;

  // Sequencer states. The encoding is fixed so debug taps and checkers can
  // compare against plain 2-bit values.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Pure combinational: a lone requester wins
// outright; on a tie the client that was not served last wins.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic any_req,
  output logic winner
);

  // Resolve the winner from the current requests and the fairness pointer.
  always_comb begin
    any_req = req0 | req1;
    winner  = 1'b0;
    if (req0 && req1) begin
      winner = ~last;
    end else if (req1) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/shift_load_ctrl.sv
// Sequencer and two-client arbiter for a shared parallel-load/serial-shift
// register. One granted word is loaded with a single ld pulse, then shifted
// out over WIDTH cycles while frame_valid is high, then the client is acked.
//
// Client handshake: a client raises reqN and holds it (with dataN stable
// until granted) until it sees a one-cycle ackN. dataN is sampled only on
// the grant edge. Dropping reqN after the grant does not cancel the
// transfer; it still completes and is still acked. Requests are only looked
// at in IDLE, so anything raised during LOAD/SHIFT/DONE waits for IDLE.
module shift_load_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int   WIDTH = DEFAULT_WIDTH,
  parameter logic FILL  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             ld,
  output logic [WIDTH-1:0] pd_out,
  output logic             d_fill,
  output logic             frame_valid,
  output logic             busy,
  output logic             gnt,
  output logic             ack0,
  output logic             ack1,
  output state_t           dbg_state
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             any_req;
  logic             winner;

  rr_arb2 u_arb (
    .req0    (req0),
    .req1    (req1),
    .last    (last),
    .any_req (any_req),
    .winner  (winner)
  );

  // The serial fill bit never changes.
  assign d_fill    = FILL;
  assign dbg_state = state;

  // Sequencer: state, bit counter, data latch, fairness pointer and all
  // registered strobes. Each output is set on the edge that enters the
  // state it belongs to, so it lines up exactly with that state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      last        <= 1'b1;
      gnt         <= 1'b0;
      pd_out      <= '0;
      ld          <= 1'b0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
    end else begin
      ld   <= 1'b0;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            state  <= ST_LOAD;
            gnt    <= winner;
            pd_out <= winner ? data1 : data0;
            ld     <= 1'b1;
            busy   <= 1'b1;
          end
        end
        ST_LOAD: begin
          state       <= ST_SHIFT;
          cnt         <= '0;
          frame_valid <= 1'b1;
        end
        ST_SHIFT: begin
          // Explicit terminal compare; the counter is not assumed to wrap
          // at WIDTH.
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            state       <= ST_DONE;
            frame_valid <= 1'b0;
            ack0        <= ~gnt;
            ack1        <= gnt;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          last  <= gnt;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Never acknowledge both clients at once.
  a_ack_onehot: assert property (@(posedge clk) disable iff (!reset)
    !(ack0 && ack1));

  // The load strobe is a single-cycle pulse.
  a_ld_pulse: assert property (@(posedge clk) disable iff (!reset)
    ld |=> !ld);

endmodule

// File: tb/tb_shift_load_ctrl.sv
// Bench for shift_load_ctrl: a 4-bit/FILL=0 instance for the main scenarios
// and an 8-bit/FILL=1 instance for the wide case. A behavioural shift
// register on each instance turns ld/pd_out/d_fill into a serial stream.
module tb_shift_load_ctrl;
  import shift_ctrl_pkg::*;

  localparam int W  = 4;
  localparam int W8 = 8;

  int n_vec = 0;
  int n_err = 0;
  int model_last;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 4-bit instance ----------------
  logic         req0, req1;
  logic [W-1:0] data0, data1;
  logic         ld, d_fill, frame_valid, busy, gnt, ack0, ack1;
  logic [W-1:0] pd_out;
  state_t       dbg_state;

  shift_load_ctrl #(.WIDTH(W), .FILL(1'b0)) u_dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .data0(data0), .data1(data1), .ld(ld), .pd_out(pd_out),
    .d_fill(d_fill), .frame_valid(frame_valid), .busy(busy), .gnt(gnt),
    .ack0(ack0), .ack1(ack1), .dbg_state(dbg_state)
  );

  // ---------------- 8-bit instance ----------------
  logic          r8_req0, r8_req1;
  logic [W8-1:0] r8_data0, r8_data1;
  logic          r8_ld, r8_d_fill, r8_fv, r8_busy, r8_gnt, r8_ack0, r8_ack1;
  logic [W8-1:0] r8_pd_out;
  state_t        r8_state;

  shift_load_ctrl #(.WIDTH(W8), .FILL(1'b1)) u_dut8 (
    .clk(clk), .reset(reset), .req0(r8_req0), .req1(r8_req1),
    .data0(r8_data0), .data1(r8_data1), .ld(r8_ld), .pd_out(r8_pd_out),
    .d_fill(r8_d_fill), .frame_valid(r8_fv), .busy(r8_busy), .gnt(r8_gnt),
    .ack0(r8_ack0), .ack1(r8_ack1), .dbg_state(r8_state)
  );

  // ---------------- shift register plants (MSB out first) ----------------
  logic [W-1:0]  sreg;
  logic [W8-1:0] sreg8;
  always @(posedge clk) begin
    if (ld) sreg <= pd_out;
    else    sreg <= {sreg[W-2:0], d_fill};
    if (r8_ld) sreg8 <= r8_pd_out;
    else       sreg8 <= {sreg8[W8-2:0], r8_d_fill};
  end

  // ---------------- per-cycle capture of the 4-bit instance ----------------
  logic         obs_ld   [0:15];
  logic         obs_fv   [0:15];
  logic         obs_busy [0:15];
  logic         obs_ack0 [0:15];
  logic         obs_ack1 [0:15];
  logic         obs_gnt  [0:15];
  logic         obs_ser  [0:15];
  logic [W-1:0] obs_pd   [0:15];
  logic [1:0]   obs_st   [0:15];

  // Record cycles k_from..k_to, counted from the grant edge (k=1 is the
  // cycle right after the edge that sampled the request).
  task automatic watch(input int k_from, input int k_to);
    for (int k = k_from; k <= k_to; k++) begin
      @(negedge clk);
      obs_ld[k]   = ld;
      obs_fv[k]   = frame_valid;
      obs_busy[k] = busy;
      obs_ack0[k] = ack0;
      obs_ack1[k] = ack1;
      obs_gnt[k]  = gnt;
      obs_ser[k]  = sreg[W-1];
      obs_pd[k]   = pd_out;
      obs_st[k]   = dbg_state;
    end
  endtask

  // Round-robin rule: lone requester wins, a tie goes to the one not served last.
  function automatic int pick(input bit r0, input bit r1, input int last);
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
    return (last == 0) ? 1 : 0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_last = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if ({ld, frame_valid, busy, gnt, ack0, ack1} !== 6'b0) begin
      n_err++; $display("FAIL reset_strobes got %b exp 000000", {ld, frame_valid, busy, gnt, ack0, ack1});
    end
    n_vec++; if (pd_out !== 4'h0) begin
      n_err++; $display("FAIL reset_pd got %h exp 0", pd_out);
    end
    n_vec++; if (dbg_state !== ST_IDLE) begin
      n_err++; $display("FAIL reset_state got %0d exp 0", dbg_state);
    end
    n_vec++; if (d_fill !== 1'b0) begin
      n_err++; $display("FAIL reset_dfill got %b exp 0", d_fill);
    end
    reset = 1'b1;
    model_last = 1;
    repeat (2) @(negedge clk);
    n_vec++; if (busy !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_err++; $display("FAIL reset_idle busy %b state %0d exp 0 0", busy, dbg_state);
    end
  endtask

  task automatic test_single();
    logic [W-1:0] word;
    int es;
    word = 4'b1011;
    req0 = 1'b1; data0 = word; req1 = 1'b0;
    watch(1, W + 2);
    req0 = 1'b0;
    watch(W + 3, W + 3);
    for (int k = 1; k <= W + 3; k++) begin
      if (k == 1) es = 1; else if (k <= W + 1) es = 2; else if (k == W + 2) es = 3; else es = 0;
      n_vec++; if (obs_ld[k] !== (k == 1)) begin
        n_err++; $display("FAIL single_ld k=%0d got %b exp %b", k, obs_ld[k], (k == 1));
      end
      n_vec++; if (obs_fv[k] !== (k >= 2 && k <= W + 1)) begin
        n_err++; $display("FAIL single_fv k=%0d got %b exp %b", k, obs_fv[k], (k >= 2 && k <= W + 1));
      end
      n_vec++; if (obs_busy[k] !== (k <= W + 2)) begin
        n_err++; $display("FAIL single_busy k=%0d got %b exp %b", k, obs_busy[k], (k <= W + 2));
      end
      n_vec++; if (obs_ack0[k] !== (k == W + 2) || obs_ack1[k] !== 1'b0) begin
        n_err++; $display("FAIL single_ack k=%0d got %b%b exp %b0", k, obs_ack0[k], obs_ack1[k], (k == W + 2));
      end
      n_vec++; if (obs_st[k] !== 2'(es)) begin
        n_err++; $display("FAIL single_state k=%0d got %0d exp %0d", k, obs_st[k], es);
      end
    end
    for (int j = 0; j < W; j++) begin
      n_vec++; if (obs_ser[2 + j] !== word[W - 1 - j]) begin
        n_err++; $display("FAIL single_serial bit%0d got %b exp %b", j, obs_ser[2 + j], word[W - 1 - j]);
      end
    end
    n_vec++; if (obs_gnt[1] !== 1'b0 || obs_pd[W + 3] !== word) begin
      n_err++; $display("FAIL single_gnt_pd got %b/%h exp 0/%h", obs_gnt[1], obs_pd[W + 3], word);
    end
    model_last = 0;
  endtask

  task automatic test_back_to_back();
    int w;
    logic [W-1:0] word;
    do_reset();
    req0 = 1'b1; req1 = 1'b1; data0 = 4'hA; data1 = 4'h5;
    for (int t = 0; t < 4; t++) begin
      w = pick(1'b1, 1'b1, model_last);
      word = (w == 1) ? 4'h5 : 4'hA;
      watch(1, W + 3);
      n_vec++; if (w !== (t % 2)) begin
        n_err++; $display("FAIL b2b_order t=%0d model %0d exp %0d", t, w, t % 2);
      end
      n_vec++; if (obs_ld[1] !== 1'b1) begin
        n_err++; $display("FAIL b2b_ld_start t=%0d got %b exp 1", t, obs_ld[1]);
      end
      for (int k = 2; k <= W + 3; k++) begin
        n_vec++; if (obs_ld[k] !== 1'b0) begin
          n_err++; $display("FAIL b2b_ld_gap t=%0d k=%0d got %b exp 0", t, k, obs_ld[k]);
        end
      end
      n_vec++; if (obs_gnt[1] !== 1'(w) || obs_pd[1] !== word) begin
        n_err++; $display("FAIL b2b_gnt t=%0d got %b/%h exp %0d/%h", t, obs_gnt[1], obs_pd[1], w, word);
      end
      n_vec++; if (obs_ack0[W + 2] !== (w == 0) || obs_ack1[W + 2] !== (w == 1)) begin
        n_err++; $display("FAIL b2b_ack t=%0d got %b%b exp winner %0d", t, obs_ack0[W + 2], obs_ack1[W + 2], w);
      end
      for (int j = 0; j < W; j++) begin
        n_vec++; if (obs_ser[2 + j] !== word[W - 1 - j]) begin
          n_err++; $display("FAIL b2b_serial t=%0d bit%0d got %b exp %b", t, j, obs_ser[2 + j], word[W - 1 - j]);
        end
      end
      model_last = w;
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tie();
    do_reset();
    req1 = 1'b1; data1 = 4'($urandom_range(0, 15)); req0 = 1'b0;
    watch(1, W + 2);
    n_vec++; if (obs_gnt[1] !== 1'b1 || obs_ack1[W + 2] !== 1'b1) begin
      n_err++; $display("FAIL tie_solo1 gnt %b ack1 %b exp 1 1", obs_gnt[1], obs_ack1[W + 2]);
    end
    model_last = 1;
    req0 = 1'b1; data0 = 4'($urandom_range(0, 15));
    watch(W + 3, W + 3);
    watch(1, W + 2);
    n_vec++; if (obs_gnt[1] !== 1'(pick(1'b1, 1'b1, model_last)) || obs_pd[1] !== data0) begin
      n_err++; $display("FAIL tie_first gnt %b pd %h exp 0 %h", obs_gnt[1], obs_pd[1], data0);
    end
    n_vec++; if (obs_ack0[W + 2] !== 1'b1) begin
      n_err++; $display("FAIL tie_ack0 got %b exp 1", obs_ack0[W + 2]);
    end
    model_last = 0;
    req0 = 1'b0; req1 = 1'b0;
    watch(W + 3, W + 3);
  endtask

  task automatic test_drop();
    int fv_cnt;
    logic [W-1:0] w0;
    w0 = 4'($urandom_range(0, 15));
    req0 = 1'b1; data0 = w0; req1 = 1'b0;
    watch(1, 3);
    req0 = 1'b0; req1 = 1'b1; data1 = 4'($urandom_range(0, 15));
    watch(4, W + 2);
    fv_cnt = 0;
    for (int k = 1; k <= W + 2; k++) fv_cnt += int'(obs_fv[k]);
    n_vec++; if (fv_cnt !== W) begin
      n_err++; $display("FAIL drop_fv_len got %0d exp %0d", fv_cnt, W);
    end
    n_vec++; if (obs_ack0[W + 2] !== 1'b1 || obs_ack1[W + 2] !== 1'b0) begin
      n_err++; $display("FAIL drop_ack got %b%b exp 10", obs_ack0[W + 2], obs_ack1[W + 2]);
    end
    n_vec++; if (obs_gnt[W + 2] !== 1'b0 || obs_pd[W + 2] !== w0) begin
      n_err++; $display("FAIL drop_hold got %b/%h exp 0/%h", obs_gnt[W + 2], obs_pd[W + 2], w0);
    end
    model_last = 0;
    watch(W + 3, W + 3);
    n_vec++; if (obs_busy[W + 3] !== 1'b0) begin
      n_err++; $display("FAIL drop_idle busy got %b exp 0", obs_busy[W + 3]);
    end
    watch(1, W + 2);
    n_vec++; if (obs_gnt[1] !== 1'(pick(1'b0, 1'b1, model_last)) || obs_pd[1] !== data1) begin
      n_err++; $display("FAIL drop_next gnt %b pd %h exp 1 %h", obs_gnt[1], obs_pd[1], data1);
    end
    n_vec++; if (obs_ack1[W + 2] !== 1'b1 || obs_ack0[W + 2] !== 1'b0) begin
      n_err++; $display("FAIL drop_next_ack got %b%b exp 01", obs_ack0[W + 2], obs_ack1[W + 2]);
    end
    model_last = 1;
    req1 = 1'b0;
    watch(W + 3, W + 3);
  endtask

  task automatic test_reset_mid();
    int w;
    logic [W-1:0] word;
    // Serve client 0 first so the fairness pointer favours client 1.
    req0 = 1'b1; data0 = 4'($urandom_range(0, 15)); req1 = 1'b0;
    watch(1, W + 2);
    req0 = 1'b0;
    watch(W + 3, W + 3);
    model_last = 0;
    req1 = 1'b1; data1 = 4'($urandom_range(0, 15));
    watch(1, 3);
    reset = 1'b0;
    #1;
    n_vec++; if ({ld, frame_valid, busy, ack0, ack1, gnt} !== 6'b0) begin
      n_err++; $display("FAIL rmid_async got %b exp 000000", {ld, frame_valid, busy, ack0, ack1, gnt});
    end
    n_vec++; if (pd_out !== 4'h0 || dbg_state !== ST_IDLE) begin
      n_err++; $display("FAIL rmid_regs pd %h state %0d exp 0 0", pd_out, dbg_state);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_vec++; if (ack0 !== 1'b0 || ack1 !== 1'b0 || busy !== 1'b0) begin
        n_err++; $display("FAIL rmid_held c=%0d ack %b%b busy %b exp 00 0", c, ack0, ack1, busy);
      end
    end
    req0 = 1'b1; data0 = 4'($urandom_range(0, 15));
    reset = 1'b1;
    model_last = 1;
    w = pick(1'b1, 1'b1, model_last);
    word = data0;
    watch(1, W + 2);
    n_vec++; if (obs_ld[1] !== 1'b1 || obs_gnt[1] !== 1'(w) || obs_pd[1] !== word) begin
      n_err++; $display("FAIL rmid_fresh ld %b gnt %b pd %h exp 1 %0d %h", obs_ld[1], obs_gnt[1], obs_pd[1], w, word);
    end
    n_vec++; if (obs_ack0[W + 2] !== 1'b1 || obs_ack1[W + 2] !== 1'b0) begin
      n_err++; $display("FAIL rmid_ack got %b%b exp 10", obs_ack0[W + 2], obs_ack1[W + 2]);
    end
    for (int j = 0; j < W; j++) begin
      n_vec++; if (obs_ser[2 + j] !== word[W - 1 - j]) begin
        n_err++; $display("FAIL rmid_serial bit%0d got %b exp %b", j, obs_ser[2 + j], word[W - 1 - j]);
      end
    end
    model_last = w;
    req0 = 1'b0;
    watch(W + 3, W + 3);
    watch(1, W + 2);
    n_vec++; if (obs_gnt[1] !== 1'b1 || obs_ack1[W + 2] !== 1'b1) begin
      n_err++; $display("FAIL rmid_rereq gnt %b ack1 %b exp 1 1", obs_gnt[1], obs_ack1[W + 2]);
    end
    model_last = 1;
    req1 = 1'b0;
    watch(W + 3, W + 3);
  endtask

  task automatic test_random();
    int w, fv_cnt;
    logic [W-1:0] word;
    for (int t = 0; t < 24; t++) begin
      if (!req0 && !req1) begin
        req0 = 1'($urandom_range(0, 1));
        req1 = req0 ? 1'($urandom_range(0, 1)) : 1'b1;
        if (req0) data0 = 4'($urandom_range(0, 15));
        if (req1) data1 = 4'($urandom_range(0, 15));
      end
      w = pick(req0, req1, model_last);
      word = (w == 1) ? data1 : data0;
      watch(1, W + 2);
      fv_cnt = 0;
      for (int k = 1; k <= W + 2; k++) fv_cnt += int'(obs_fv[k]);
      n_vec++; if (obs_gnt[1] !== 1'(w) || obs_pd[1] !== word) begin
        n_err++; $display("FAIL rand_grant t=%0d got %b/%h exp %0d/%h", t, obs_gnt[1], obs_pd[1], w, word);
      end
      n_vec++; if (fv_cnt !== W || obs_ld[1] !== 1'b1) begin
        n_err++; $display("FAIL rand_frame t=%0d fv %0d ld %b exp %0d 1", t, fv_cnt, obs_ld[1], W);
      end
      n_vec++; if (obs_ack0[W + 2] !== (w == 0) || obs_ack1[W + 2] !== (w == 1)) begin
        n_err++; $display("FAIL rand_ack t=%0d got %b%b exp winner %0d", t, obs_ack0[W + 2], obs_ack1[W + 2], w);
      end
      for (int j = 0; j < W; j++) begin
        n_vec++; if (obs_ser[2 + j] !== word[W - 1 - j]) begin
          n_err++; $display("FAIL rand_serial t=%0d bit%0d got %b exp %b", t, j, obs_ser[2 + j], word[W - 1 - j]);
        end
      end
      model_last = w;
      // The acked client may keep requesting with a new word, or drop out.
      if (w == 0) begin
        req0 = 1'($urandom_range(0, 1));
        data0 = 4'($urandom_range(0, 15));
      end else begin
        req1 = 1'($urandom_range(0, 1));
        data1 = 4'($urandom_range(0, 15));
      end
      watch(W + 3, W + 3);
      n_vec++; if (obs_busy[W + 3] !== 1'b0 || obs_st[W + 3] !== 2'd0) begin
        n_err++; $display("FAIL rand_idle t=%0d busy %b state %0d exp 0 0", t, obs_busy[W + 3], obs_st[W + 3]);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_width8();
    logic [W8-1:0] word;
    logic          ser8 [0:15];
    int fv_cnt, ld_cnt;
    word = 8'($urandom_range(0, 255));
    r8_req0 = 1'b1; r8_data0 = word;
    fv_cnt = 0; ld_cnt = 0;
    for (int k = 1; k <= W8 + 3; k++) begin
      @(negedge clk);
      fv_cnt += int'(r8_fv);
      ld_cnt += int'(r8_ld);
      ser8[k] = sreg8[W8-1];
      n_vec++; if (r8_d_fill !== 1'b1) begin
        n_err++; $display("FAIL w8_dfill k=%0d got %b exp 1", k, r8_d_fill);
      end
      if (k == W8 + 2) begin
        n_vec++; if (r8_ack0 !== 1'b1 || r8_ack1 !== 1'b0) begin
          n_err++; $display("FAIL w8_ack got %b%b exp 10", r8_ack0, r8_ack1);
        end
        r8_req0 = 1'b0;
      end
    end
    n_vec++; if (fv_cnt !== W8) begin
      n_err++; $display("FAIL w8_fv_len got %0d exp %0d", fv_cnt, W8);
    end
    n_vec++; if (ld_cnt !== 1) begin
      n_err++; $display("FAIL w8_ld_count got %0d exp 1", ld_cnt);
    end
    for (int j = 0; j < W8; j++) begin
      n_vec++; if (ser8[2 + j] !== word[W8 - 1 - j]) begin
        n_err++; $display("FAIL w8_serial bit%0d got %b exp %b", j, ser8[2 + j], word[W8 - 1 - j]);
      end
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    reset = 1'b0;
    req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
    r8_req0 = 1'b0; r8_req1 = 1'b0; r8_data0 = '0; r8_data1 = '0;
    model_last = 1;
    test_reset();
    test_single();
    test_back_to_back();
    test_tie();
    test_drop();
    test_reset_mid();
    test_random();
    test_width8();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #400000;
    $display("FAIL timeout after 400000 ns, vectors %0d", n_vec);
    $fatal(1, "timeout");
  end

endmodule
